// File: rtl/clkdiv_pkg.sv
// Shared definitions for the 4-way clock divider and its receive-side detector.
package clkdiv_pkg;

    localparam int NUM_SEL = 4;

    // Select codes, one per divide ratio
    localparam logic [1:0] SEL_DIV256 = 2'b00;
    localparam logic [1:0] SEL_DIV128 = 2'b01;
    localparam logic [1:0] SEL_DIV64  = 2'b10;
    localparam logic [1:0] SEL_DIV32  = 2'b11;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } det_state_e;

    // Result of classifying one measured period
    typedef struct packed {
        logic       hit;
        logic [1:0] sel;
    } class_t;

    // Nominal divided-clock period in clk_i cycles for a select code
    function automatic int unsigned nom_period(input logic [1:0] sel);
        case (sel)
            SEL_DIV256: return 256;
            SEL_DIV128: return 128;
            SEL_DIV64:  return 64;
            default:    return 32;
        endcase
    endfunction

    // Find the class whose nominal period lies within +/- tol of p
    function automatic class_t classify(input int unsigned p, input int unsigned tol);
        class_t r;
        r = '0;
        for (int s = 0; s < NUM_SEL; s++) begin
            int unsigned n;
            int unsigned d;
            n = nom_period(2'(s));
            d = (p >= n) ? (p - n) : (n - p);
            if (d <= tol) begin
                r.hit = 1'b1;
                r.sel = 2'(s);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer plus registered rising-edge pulse for an async input.
// The stages reset to 1 so a line that is already high when reset releases
// does not produce a false edge; a real rise needs a low level seen first.
module sync_rise (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic rise_o
);

    // sh_q[0..1] synchronize, sh_q[2] holds the previous synchronized level
    logic [2:0] sh_q;

    // Shift the input through the synchronizer and register the edge pulse
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sh_q   <= '1;
            rise_o <= 1'b0;
        end else begin
            sh_q   <= {sh_q[1:0], d_i};
            rise_o <= sh_q[1] & ~sh_q[2];
        end
    end

endmodule

// File: rtl/clkdiv_detect.sv
// Measures the period of an incoming divided clock in clk_i cycles, classifies
// it against the four divider ratios and reports the select code once stable.
module clkdiv_detect
    import clkdiv_pkg::*;
#(
    parameter int CNT_W    = 10,
    parameter int TOL      = 2,
    parameter int LOCK_CNT = 2,
    parameter int TIMEOUT  = 600
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             dclk_i,
    output logic [CNT_W-1:0] period_o,
    output logic             meas_vld_o,
    output logic [1:0]       sel_o,
    output logic             locked_o,
    output logic             err_o,
    output logic             timeout_o
);

    localparam int                MW      = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [31:0]       TO_LIM  = TIMEOUT;
    localparam logic [MW-1:0]     LOCK_N  = MW'(LOCK_CNT);

    logic             rise;
    det_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;      // cycles since the last accepted edge
    logic [1:0]       cand_q;
    logic [MW-1:0]    mcnt_q;
    logic             pend_q;     // edge swallowed by a timeout, replayed in SEARCH
    class_t           cls;
    logic [MW-1:0]    mcnt_nxt;

    sync_rise u_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (dclk_i),
        .rise_o (rise)
    );

    // Classify the running count and work out the match count if this edge matches
    always_comb begin
        cls      = classify(32'(cnt_q), TOL);
        mcnt_nxt = MW'(1);
        if (mcnt_q != '0 && cls.sel == cand_q) mcnt_nxt = mcnt_q + 1'b1;
    end

    // Period counter, detector state machine and registered outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_SEARCH;
            cnt_q      <= '0;
            cand_q     <= '0;
            mcnt_q     <= '0;
            pend_q     <= 1'b0;
            period_o   <= '0;
            meas_vld_o <= 1'b0;
            sel_o      <= SEL_DIV256;
            locked_o   <= 1'b0;
            err_o      <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            meas_vld_o <= 1'b0;
            err_o      <= 1'b0;
            timeout_o  <= 1'b0;
            pend_q     <= 1'b0;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;

            case (state_q)
                ST_SEARCH: begin
                    // A replayed edge happened one cycle ago, so start at 2
                    if (rise || pend_q) begin
                        cnt_q   <= pend_q ? CNT_W'(2) : CNT_W'(1);
                        mcnt_q  <= '0;
                        state_q <= ST_MEASURE;
                    end
                end
                default: begin
                    if (32'(cnt_q) >= TO_LIM) begin
                        timeout_o <= 1'b1;
                        locked_o  <= 1'b0;
                        mcnt_q    <= '0;
                        pend_q    <= rise;
                        state_q   <= ST_SEARCH;
                    end else if (rise) begin
                        cnt_q      <= CNT_W'(1);
                        period_o   <= cnt_q;
                        meas_vld_o <= 1'b1;
                        if (!cls.hit) begin
                            err_o    <= 1'b1;
                            locked_o <= 1'b0;
                            mcnt_q   <= '0;
                            state_q  <= ST_MEASURE;
                        end else if (state_q == ST_LOCKED) begin
                            if (cls.sel != sel_o) begin
                                err_o    <= 1'b1;
                                locked_o <= 1'b0;
                                cand_q   <= cls.sel;
                                mcnt_q   <= MW'(1);
                                state_q  <= ST_MEASURE;
                            end
                        end else begin
                            cand_q <= cls.sel;
                            mcnt_q <= mcnt_nxt;
                            if (mcnt_nxt >= LOCK_N) begin
                                locked_o <= 1'b1;
                                sel_o    <= cls.sel;
                                state_q  <= ST_LOCKED;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_detect.sv
// Randomized bench for clkdiv_detect against a timestamp-based reference model.
module tb_clkdiv_detect;

    localparam int CNT_W    = 10;
    localparam int TOL      = 2;
    localparam int LOCK_CNT = 2;
    localparam int TIMEOUT  = 600;

    logic             clk_i  = 1'b0;
    logic             rstn_i = 1'b0;
    logic             dclk_i = 1'b0;
    logic [CNT_W-1:0] period_o;
    logic             meas_vld_o;
    logic [1:0]       sel_o;
    logic             locked_o;
    logic             err_o;
    logic             timeout_o;

    clkdiv_detect #(
        .CNT_W    (CNT_W),
        .TOL      (TOL),
        .LOCK_CNT (LOCK_CNT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .dclk_i     (dclk_i),
        .period_o   (period_o),
        .meas_vld_o (meas_vld_o),
        .sel_o      (sel_o),
        .locked_o   (locked_o),
        .err_o      (err_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int NOM [4] = '{256, 128, 64, 32};

    int k = 0;            // posedge index
    int q_rise[$];        // edge index at which each detected rise is acted on
    bit prev = 1'b1;      // last sampled dclk level (reset counts as high)
    bit meas_on = 1'b0;   // an edge has been seen, periods are being timed
    int last = 0;         // edge index of the previous accepted rise
    int cand = 0;
    int run = 0;
    int m_period = 0;
    int m_sel = 0;
    bit m_vld = 0, m_lock = 0, m_err = 0, m_to = 0;

    function automatic int match_class(input int p);
        for (int s = 0; s < 4; s++) begin
            int d;
            d = p - NOM[s];
            if (d < 0) d = -d;
            if (d <= TOL) return s;
        end
        return -1;
    endfunction

    // Advance the model by one clk_i edge
    always @(posedge clk_i) begin
        bit rise_now;
        int p, c;
        k++;
        m_vld = 0; m_err = 0; m_to = 0;
        if (!rstn_i) begin
            q_rise.delete();
            prev = 1'b1; meas_on = 0; last = 0; cand = 0; run = 0;
            m_period = 0; m_sel = 0; m_lock = 0;
        end else begin
            if (dclk_i && !prev) q_rise.push_back(k + 3);
            prev = dclk_i;
            rise_now = 0;
            if (q_rise.size() > 0 && q_rise[0] == k) begin
                rise_now = 1;
                void'(q_rise.pop_front());
            end
            if (!meas_on) begin
                if (rise_now) begin
                    meas_on = 1; last = k;
                end
            end else if (k - last >= TIMEOUT) begin
                m_to = 1; m_lock = 0; run = 0;
                if (rise_now) last = k;
                else meas_on = 0;
            end else if (rise_now) begin
                p = k - last;
                last = k;
                m_period = (p > 1023) ? 1023 : p;
                m_vld = 1;
                c = match_class(p);
                if (c < 0) begin
                    m_err = 1; run = 0; m_lock = 0;
                end else if (m_lock) begin
                    if (c != m_sel) begin
                        m_err = 1; m_lock = 0; cand = c; run = 1;
                    end
                end else begin
                    if (run > 0 && c == cand) run++;
                    else begin cand = c; run = 1; end
                    if (run >= LOCK_CNT) begin m_lock = 1; m_sel = cand; end
                end
            end
        end
    end

    int dut_meas = 0, mdl_meas = 0, dut_to = 0, mdl_to = 0, dut_er = 0, mdl_er = 0;

    // Compare every output against the model midway between edges
    always @(negedge clk_i) begin
        logic [15:0] exp_v;
        exp_v = {10'(m_period), m_vld, 2'(m_sel), m_lock, m_err, m_to};
        chk("outs", {16'h0, period_o, meas_vld_o, sel_o, locked_o, err_o, timeout_o},
            {16'h0, exp_v});
        dut_meas += int'(meas_vld_o); mdl_meas += int'(m_vld);
        dut_to   += int'(timeout_o);  mdl_to   += int'(m_to);
        dut_er   += int'(err_o);      mdl_er   += int'(m_err);
    end

    // ---------------- stimulus ----------------
    // One dclk period of `total` cycles, high for `hi`; optional 1-cycle reset at index rst_at
    task automatic run_period(input int total, input int hi, input int rst_at);
        for (int i = 0; i < total; i++) begin
            @(negedge clk_i);
            #1;
            dclk_i = (i < hi);
            if (i == rst_at) begin
                rstn_i = 1'b0;
                #1;
                chk("rst_async", {16'h0, period_o, meas_vld_o, sel_o, locked_o, err_o, timeout_o}, 32'h0);
            end else begin
                rstn_i = 1'b1;
            end
        end
    endtask

    task automatic run_n(input int n, input int per);
        for (int i = 0; i < n; i++) run_period(per, per / 2, -1);
    endtask

    initial begin
        int r, s, n, per, hi, rst;
        repeat (3) @(negedge clk_i);
        #1 rstn_i = 1'b1;

        run_n(4, 256);                                   // lock on 00
        run_n(4, 32);                                    // class change, relock on 11
        run_period(128, 64, -1);
        run_period(126, 60, -1);
        run_period(130, 70, -1);
        run_period(128, 64, -1);
        run_period(131, 65, -1);                         // out of band after lock on 01
        run_n(4, 64);
        run_period(700, 0, -1);                          // clock lost
        run_n(4, 64);
        run_n(4, 128);
        run_period(128, 64, 40);                         // reset while dclk high
        run_n(4, 128);
        run_period(128, 64, 100);                        // reset while dclk low
        run_n(4, 128);
        run_n(3, TIMEOUT);                               // period at the timeout limit
        run_n(3, TIMEOUT - 1);
        run_n(3, 2);                                     // fastest toggling

        repeat (30) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                s = int'($urandom_range(0, 3));
                n = int'($urandom_range(1, 5));
                repeat (n) begin
                    per = NOM[s] + int'($urandom_range(0, 6)) - 3;
                    hi  = int'($urandom_range(1, per - 1));
                    rst = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, per - 2)) : -1;
                    run_period(per, hi, rst);
                end
            end else if (r < 8) begin
                per = int'($urandom_range(2, 700));
                run_period(per, int'($urandom_range(1, per - 1)), -1);
            end else if (r == 8) begin
                run_period(int'($urandom_range(100, 700)), 0, -1);
            end else begin
                repeat (3) begin
                    per = int'($urandom_range(2, 10));
                    run_period(per, int'($urandom_range(1, per - 1)), -1);
                end
            end
        end

        repeat (10) @(negedge clk_i);
        #2;
        chk("meas_pulses", dut_meas, mdl_meas);
        chk("timeout_pulses", dut_to, mdl_to);
        chk("err_pulses", dut_er, mdl_er);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
